// File: rtl/computer_player.sv
// Automated tug-of-war opponent: LFSR-driven key presses whose
// average rate scales with the 3-bit difficulty input.
module computer_player #(
   parameter int TICK_DIV = 50_000_000 / 8,
   parameter int HOLDOFF  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [2:0] difficulty,
   output logic       press,
   output logic [9:0] rand_out
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

   typedef enum logic [1:0] {IDLE, WAIT, PRESS, HOLD} state_t;

   state_t        state, state_n;
   logic [TW-1:0] tick_cnt;
   logic [HW-1:0] hold_cnt, hold_cnt_n;
   logic [9:0]    q, thr;
   logic          tick, hit, press_n;

   assign tick     = (tick_cnt == TICK_LAST);
   assign thr      = {{1'b0, difficulty} + 4'd1, 6'b0};
   assign hit      = tick && (q < thr);
   assign rand_out = q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

   // XNOR feedback: all-zero start is legal, all-ones is the lock-up state
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else
         q <= {q[8:0], ~(q[9] ^ q[6])};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
         press    <= 1'b0;
      end else begin
         state    <= state_n;
         hold_cnt <= hold_cnt_n;
         press    <= press_n;
      end
   end

   always_comb begin
      state_n    = state;
      hold_cnt_n = hold_cnt;
      unique case (state)
         IDLE: begin
            if (enable)
               state_n = WAIT;
         end
         WAIT: begin
            if (!enable)
               state_n = IDLE;
            else if (hit)
               state_n = PRESS;
         end
         PRESS: begin
            if (!enable) begin
               state_n = IDLE;
            end else begin
               state_n    = HOLD;
               hold_cnt_n = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (!enable)
               state_n = IDLE;
            else if (hold_cnt == '0)
               state_n = WAIT;
            else
               hold_cnt_n = hold_cnt - 1'b1;
         end
         default: state_n = IDLE;
      endcase
      // press mirrors a dedicated flop so the pin never sees decode logic
      press_n = (state_n == PRESS);
   end

endmodule

// File: tb/tb_computer_player.sv
// Scoreboard bench for computer_player: a per-cycle model pushes
// expected outputs, a negedge monitor pops and compares.
module tb_computer_player;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [2:0] difficulty = 3'd0;
   logic       press0, press1;
   logic [9:0] rand0, rand1;

   computer_player #(.TICK_DIV(1), .HOLDOFF(4)) dut0 (
      .clk(clk), .reset(reset), .enable(enable),
      .difficulty(difficulty), .press(press0), .rand_out(rand0)
   );

   computer_player #(.TICK_DIV(4), .HOLDOFF(4)) dut1 (
      .clk(clk), .reset(reset), .enable(enable),
      .difficulty(difficulty), .press(press1), .rand_out(rand1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       p0;
      logic       p1;
      logic [9:0] q;
      int         thr0;
      logic       dtick1;
   } exp_t;

   typedef enum {M_IDLE, M_WAIT, M_PRESS, M_HOLD} mst_t;

   exp_t exp_q[$];
   int   nvec = 0;
   int   nfail = 0;

   mst_t ms[2];
   int   mtc[2];
   int   mhc[2];
   int   mq;
   int   mpress_cnt = 0;
   bit   last_p0 = 0;

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int td(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   task automatic model_reset();
      mq = 0;
      for (int k = 0; k < 2; k++) begin
         ms[k]  = M_IDLE;
         mtc[k] = 0;
         mhc[k] = 0;
      end
   endtask

   task automatic model_step();
      exp_t e;
      int   thr;
      int   nq;
      logic tk[2];
      e.thr0   = 1024;
      e.dtick1 = 1'b0;
      if (reset) begin
         model_reset();
      end else begin
         thr = (int'(difficulty) + 1) * 64;
         nq  = ((mq << 1) & 1022) |
               ((((mq >> 9) & 1) == ((mq >> 6) & 1)) ? 1 : 0);
         for (int k = 0; k < 2; k++) begin
            tk[k] = (mtc[k] == td(k) - 1);
            case (ms[k])
               M_IDLE:  if (enable) ms[k] = M_WAIT;
               M_WAIT:  if (!enable) ms[k] = M_IDLE;
                        else if (tk[k] && mq < thr) ms[k] = M_PRESS;
               M_PRESS: if (!enable) ms[k] = M_IDLE;
                        else begin ms[k] = M_HOLD; mhc[k] = 3; end
               M_HOLD:  if (!enable) ms[k] = M_IDLE;
                        else if (mhc[k] == 0) ms[k] = M_WAIT;
                        else mhc[k]--;
               default: ms[k] = M_IDLE;
            endcase
            mtc[k] = tk[k] ? 0 : mtc[k] + 1;
         end
         e.thr0   = thr;
         e.dtick1 = tk[1];
         mq       = nq;
      end
      e.p0 = (ms[0] == M_PRESS);
      e.p1 = (ms[1] == M_PRESS);
      e.q  = 10'(mq);
      if (e.p0) mpress_cnt++;
      last_p0 = e.p0;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wait_press(input string nm);
      bit got = 0;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (last_p0) begin
            got = 1;
            break;
         end
      end
      chk(nm, got, 1);
   endtask

   // monitor
   logic       prev_p0 = 1'b0;
   logic [9:0] prev_r = '0;
   int         low0 = 0;
   bit         armed = 0;
   int         dcnt = 0;

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() == 0) begin
         nvec++;
         nfail++;
         $display("FAIL sb_empty: no expectation at %0t", $time);
      end else begin
         e = exp_q.pop_front();
         chk("press0", press0, e.p0);
         chk("press1", press1, e.p1);
         chk("rand0", rand0, e.q);
         chk("rand1", rand1, e.q);
         if (press0) begin
            chk("width0", prev_p0, 0);
            chk("thr0", (prev_r < e.thr0) ? 1 : 0, 1);
            if (armed) chk("gap0", (low0 >= 4) ? 1 : 0, 1);
            dcnt++;
         end
         if (press1) chk("tick1", e.dtick1, 1);
      end
      if (press0) begin
         low0  = 0;
         armed = 1;
      end else begin
         low0++;
      end
      if (!enable || reset) armed = 0;
      prev_p0 = press0;
      prev_r  = rand0;
   end

   initial begin
      int tab[10] = '{1, 3, 7, 15, 31, 63, 127, 254, 508, 1016};
      bit saw_lock;
      int m0, d0, n7, n0, mc7, mc0;

      model_reset();
      #1 reset = 1'b1;
      #2;
      chk("rst_press0", press0, 0);
      chk("rst_press1", press1, 0);
      chk("rst_rand", rand0, 0);
      cyc();
      cyc();
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("lfsr_seq", rand0, tab[i]);
         chk("lfsr_idle", press0, 0);
      end
      saw_lock = 0;
      for (int i = 10; i < 1023; i++) begin
         cyc();
         if (rand0 == 10'd1023) saw_lock = 1;
         if (i == 1022) chk("lfsr_wrap", rand0, 0);
      end
      chk("no_lockup", saw_lock, 0);

      difficulty = 3'd7;
      enable = 1'b1;
      m0 = mpress_cnt;
      d0 = dcnt;
      repeat (4092) cyc();
      enable = 1'b0;
      cyc();
      cyc();
      n7  = dcnt - d0;
      mc7 = mpress_cnt - m0;
      chk("count7", n7, mc7);
      chk("count7_nz", (n7 > 0) ? 1 : 0, 1);

      difficulty = 3'd0;
      enable = 1'b1;
      m0 = mpress_cnt;
      d0 = dcnt;
      repeat (4092) cyc();
      enable = 1'b0;
      cyc();
      cyc();
      n0  = dcnt - d0;
      mc0 = mpress_cnt - m0;
      chk("count0", n0, mc0);
      chk("order", (n0 < n7) ? 1 : 0, 1);

      difficulty = 3'd7;
      enable = 1'b1;
      wait_press("drop_wait");
      chk("drop_hi", press0, 1);
      enable = 1'b0;
      cyc();
      chk("drop_next", press0, 0);
      enable = 1'b1;
      cyc();
      chk("reen_idle", press0, 0);
      repeat (20) cyc();

      wait_press("arst_wait");
      chk("arst_hi", press0, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_press0", press0, 0);
      chk("arst_press1", press1, 0);
      chk("arst_rand", rand0, 0);
      exp_q.delete();
      model_reset();
      begin
         exp_t z;
         z.p0 = 0; z.p1 = 0; z.q = '0; z.thr0 = 1024; z.dtick1 = 0;
         exp_q.push_back(z);
      end
      cyc();
      cyc();
      enable = 1'b0;
      reset = 1'b0;
      cyc();
      chk("restart1", rand0, 1);
      cyc();
      chk("restart2", rand0, 3);
      repeat (4) cyc();
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
